// File: rtl/perf_counter_ctrl_pkg.sv
// Shared LC-3b types plus performance-counter window definitions.
package lc3b_types;

  localparam int unsigned WORD_W = 16;

  typedef logic [WORD_W-1:0] lc3b_word;
  typedef logic [2:0]        lc3b_perf_idx;

  // Counter window base; the window covers PERF_BASE .. PERF_BASE+7.
  localparam lc3b_word       PERF_BASE    = 16'hFFF8;
  localparam int unsigned    PERF_NUM_CNT = 8;

  typedef enum logic {
    PERF_IDLE    = 1'b0,
    PERF_RESPOND = 1'b1
  } perf_ctrl_state_t;

  typedef enum logic {
    PERF_OP_READ  = 1'b0,
    PERF_OP_WRITE = 1'b1
  } perf_op_t;

  // Counter index assignment within the window.
  typedef enum lc3b_perf_idx {
    PERF_ICACHE_HIT    = 3'd0,
    PERF_ICACHE_MISS   = 3'd1,
    PERF_DCACHE_HIT    = 3'd2,
    PERF_DCACHE_MISS   = 3'd3,
    PERF_L2_HIT        = 3'd4,
    PERF_L2_MISS       = 3'd5,
    PERF_BRANCH        = 3'd6,
    PERF_BR_MISPREDICT = 3'd7
  } perf_cnt_id_t;

endpackage

// File: rtl/perf_counter_ctrl_counter.sv
// Single performance counter: per-cycle increment with software load.
// Build option: define PERF_SATURATE_EN to saturate at all-ones instead of wrapping.
module perf_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             load,
  input  logic [CNT_W-1:0] load_data,
  output logic [CNT_W-1:0] count
);

  // Load beats increment; increment either wraps or saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_data;
    end else if (inc) begin
`ifdef PERF_SATURATE_EN
      if (count != '1) begin
        count <= count + CNT_W'(1);
      end
`else
      count <= count + CNT_W'(1);
`endif
    end
  end

endmodule

// File: rtl/perf_counter_ctrl.sv
// Performance counter window controller between the CPU data port and the
// cache hierarchy. Window hits are served locally with a one-cycle response;
// everything else passes through. Build option: PERF_SATURATE_EN (counters
// saturate at 0xFFFF instead of wrapping).
module perf_counter_ctrl
  import lc3b_types::*;
#(
  parameter lc3b_word    BASE_ADDR = PERF_BASE,
  parameter int unsigned NUM_CNT   = PERF_NUM_CNT,
  parameter int unsigned CNT_W     = WORD_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_CNT-1:0] event_inc,
  input  logic               mem_read,
  input  logic               mem_write,
  input  lc3b_word           mem_address,
  input  lc3b_word           mem_wdata,
  output lc3b_word           mem_rdata,
  output logic               mem_resp,
  output logic               pass_read,
  output logic               pass_write,
  output lc3b_word           pass_address,
  output lc3b_word           pass_wdata,
  input  lc3b_word           pass_rdata,
  input  logic               pass_resp
);

  perf_ctrl_state_t state_q, state_d;

  logic             hit;
  lc3b_perf_idx     idx;
  logic             accept;
  logic [NUM_CNT-1:0] load;
  logic [CNT_W-1:0] cnt [NUM_CNT];

  lc3b_word         rdata_q;
  lc3b_perf_idx     idx_q;
  perf_op_t         op_q;

  // Window decode on the live CPU address.
  assign hit = (mem_address[15:3] == BASE_ADDR[15:3]);
  assign idx = mem_address[2:0];

  // Address and write data always flow downstream unchanged.
  assign pass_address = mem_address;
  assign pass_wdata   = mem_wdata;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PERF_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, accept strobe and CPU/downstream port muxing.
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    pass_read  = mem_read & ~hit;
    pass_write = mem_write & ~hit;
    mem_resp   = pass_resp;
    mem_rdata  = pass_rdata;
    case (state_q)
      PERF_IDLE: begin
        if (hit) begin
          mem_resp  = 1'b0;
          mem_rdata = rdata_q;
          if (mem_read | mem_write) begin
            accept  = 1'b1;
            state_d = PERF_RESPOND;
          end
        end
      end
      PERF_RESPOND: begin
        mem_resp  = 1'b1;
        mem_rdata = rdata_q;
        state_d   = PERF_IDLE;
      end
      default: begin
        state_d = PERF_IDLE;
      end
    endcase
  end

  // Capture the accepted request; reads sample the pre-increment count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
      idx_q   <= '0;
      op_q    <= PERF_OP_READ;
    end else if (accept) begin
      idx_q <= idx;
      op_q  <= mem_write ? PERF_OP_WRITE : PERF_OP_READ;
      if (!mem_write) begin
        rdata_q <= WORD_W'(cnt[idx]);
      end
    end
  end

  // Latched request is kept for debug visibility only.
  logic perf_unused;
  assign perf_unused = ^{idx_q, op_q};

  // One counter per event line; a write targets exactly one of them.
  for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
    assign load[i] = accept & mem_write & (idx == lc3b_perf_idx'(i));

    perf_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc       (event_inc[i]),
      .load      (load[i]),
      .load_data (CNT_W'(mem_wdata)),
      .count     (cnt[i])
    );
  end

endmodule

// File: tb/tb_perf_counter_ctrl.sv
// Self-checking bench for perf_counter_ctrl: window reads/writes, pass-through,
// load-vs-increment priority, overflow and reset abort.
module tb_perf_counter_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  event_inc;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_resp;
  logic        pass_read;
  logic        pass_write;
  logic [15:0] pass_address;
  logic [15:0] pass_wdata;
  logic [15:0] pass_rdata;
  logic        pass_resp;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  perf_counter_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .event_inc    (event_inc),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp),
    .pass_read    (pass_read),
    .pass_write   (pass_write),
    .pass_address (pass_address),
    .pass_wdata   (pass_wdata),
    .pass_rdata   (pass_rdata),
    .pass_resp    (pass_resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counters as plain integers, plus "a response is owed".
  int m_cnt [8] = '{default: 0};
  int m_rdq     = 0;
  bit m_busy    = 1'b0;

  function automatic int bump(input int c, input logic e);
    if (!e) return c;
`ifdef PERF_SATURATE_EN
    return (c == 65535) ? c : c + 1;
`else
    return (c + 1) % 65536;
`endif
  endfunction

  wire m_hit = (mem_address >= 16'hFFF8);
  wire m_acc = !m_busy && m_hit && (mem_read || mem_write);
  wire [2:0] m_ix = 3'(mem_address - 16'hFFF8);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) m_cnt[i] <= 0;
      m_rdq  <= 0;
      m_busy <= 1'b0;
    end else begin
      for (int i = 0; i < 8; i++)
        m_cnt[i] <= (m_acc && mem_write && (int'(m_ix) == i)) ? int'(mem_wdata)
                                                             : bump(m_cnt[i], event_inc[i]);
      if (m_acc && !mem_write) m_rdq <= m_cnt[m_ix];
      m_busy <= m_acc;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pass_read",    int'(pass_read),    int'(mem_read && !m_hit));
      chk("pass_write",   int'(pass_write),   int'(mem_write && !m_hit));
      chk("pass_address", int'(pass_address), int'(mem_address));
      chk("pass_wdata",   int'(pass_wdata),   int'(mem_wdata));
      chk("mem_resp",     int'(mem_resp),     m_busy ? 1 : (m_hit ? 0 : int'(pass_resp)));
      chk("mem_rdata",    int'(mem_rdata),    (m_busy || m_hit) ? m_rdq : int'(pass_rdata));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Read with one-cycle latency check and a literal data expectation.
  task automatic do_read(input logic [15:0] addr, input int exp, input string name);
    mem_address = addr;
    mem_read    = 1'b1;
    @(negedge clk);
    chk({name, "_resp_n"}, int'(mem_resp), 0);
    tick();
    chk({name, "_resp_n1"}, int'(mem_resp), 1);
    chk({name, "_data"}, int'(mem_rdata), exp);
    mem_read = 1'b0;
    tick();
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [15:0] data,
                          input logic [7:0] ev, input logic rd_too, input string name);
    mem_address = addr;
    mem_wdata   = data;
    mem_write   = 1'b1;
    mem_read    = rd_too;
    event_inc   = ev;
    @(negedge clk);
    chk({name, "_resp_n"}, int'(mem_resp), 0);
    tick();
    chk({name, "_resp_n1"}, int'(mem_resp), 1);
    mem_write = 1'b0;
    mem_read  = 1'b0;
    event_inc = '0;
    tick();
  endtask

  initial begin
    rst_n       = 1'b1;
    event_inc   = '0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = 16'h0000;
    mem_wdata   = 16'h0000;
    pass_rdata  = 16'h0000;
    pass_resp   = 1'b0;

    // Reset with a window read pending: no response.
    #1 rst_n = 1'b0;
    mem_address = 16'hFFFE;
    mem_read    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp",  int'(mem_resp), 0);
    chk("rst_rdata", int'(mem_rdata), 0);
    mem_read = 1'b0;
    rst_n    = 1'b1;
    chk_en   = 1'b1;
    tick();

    do_read(16'hFFFE, 16'h0000, "rd_fffe_reset");

    // Five icache-hit strobes.
    event_inc = 8'h01;
    repeat (5) tick();
    event_inc = '0;
    do_read(16'hFFF8, 16'h0005, "rd_fff8");
    do_read(16'hFFF9, 16'h0000, "rd_fff9");

    // Load beats a same-cycle increment.
    do_write(16'hFFFB, 16'h1234, 8'h08, 1'b0, "wr_fffb");
    do_read(16'hFFFB, 16'h1234, "rd_fffb_load");
    event_inc = 8'h08;
    tick();
    event_inc = '0;
    do_read(16'hFFFB, 16'h1235, "rd_fffb_inc");

    // Read and write together: the write wins.
    do_write(16'hFFFA, 16'h0042, 8'h00, 1'b1, "wr_rd_fffa");
    do_read(16'hFFFA, 16'h0042, "rd_fffa");

    // Overflow at all-ones.
    do_write(16'hFFFF, 16'hFFFF, 8'h00, 1'b0, "wr_ffff");
    event_inc = 8'h80;
    tick();
    event_inc = '0;
`ifdef PERF_SATURATE_EN
    do_read(16'hFFFF, 16'hFFFF, "rd_ffff_sat");
`else
    do_read(16'hFFFF, 16'h0000, "rd_ffff_wrap");
`endif

    // Held request is re-accepted every other cycle.
    mem_address = 16'hFFFB;
    mem_read    = 1'b1;
    repeat (4) tick();
    mem_read = 1'b0;
    tick();

    // Pass-through read with a slow downstream.
    mem_address = 16'h3000;
    mem_read    = 1'b1;
    pass_rdata  = 16'hBEEF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("pt_pass_read", int'(pass_read), 1);
      chk("pt_wait_resp", int'(mem_resp), 0);
      tick();
    end
    pass_resp = 1'b1;
    @(negedge clk);
    chk("pt_resp",  int'(mem_resp), 1);
    chk("pt_rdata", int'(mem_rdata), 16'hBEEF);
    tick();
    mem_read  = 1'b0;
    pass_resp = 1'b0;
    tick();
    do_read(16'hFFF8, 16'h0005, "rd_fff8_after_pt");

    // Reset during the response cycle of a write aborts it.
    mem_address = 16'hFFFC;
    mem_wdata   = 16'h00AA;
    mem_write   = 1'b1;
    tick();
    rst_n = 1'b0;
    #1;
    chk("abort_resp", int'(mem_resp), 0);
    tick();
    chk("abort_resp_hold", int'(mem_resp), 0);
    mem_write = 1'b0;
    rst_n     = 1'b1;
    tick();
    do_read(16'hFFFC, 16'h0000, "rd_fffc_after_rst");
    do_read(16'hFFF8, 16'h0000, "rd_fff8_after_rst");

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
